// File: rtl/alu4_seq16_if.sv
// Requester and ALU-side signal bundle for the alu4_seq16 nibble sequencer.
// The abort input only exists when ALU4_SEQ_ABORT_EN is defined.
interface alu4_seq16_if #(
    parameter int NIBBLES = 4
) ();
    localparam int W = 4 * NIBBLES;

    // requester side
    logic           start;
    logic [3:0]     op;
    logic           dir;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           cin;
    logic           rin;
`ifdef ALU4_SEQ_ABORT_EN
    logic           abort;
`endif
    logic           busy;
    logic           done;
    logic [W-1:0]   result;
    logic           cout;
    logic           rout;
    logic           zero;
    logic           ovf;

    // combinational 4-bit ALU side
    logic [3:0]     alu_op;
    logic [3:0]     alu_a;
    logic [3:0]     alu_b;
    logic           alu_mci;
    logic           alu_rci;
    logic [3:0]     alu_y;
    logic           alu_mco;
    logic           alu_rco;
    logic           alu_z;
    logic           alu_v;

    modport slave (
`ifdef ALU4_SEQ_ABORT_EN
        input  abort,
`endif
        input  start, op, dir, a, b, cin, rin,
        output busy, done, result, cout, rout, zero, ovf,
        output alu_op, alu_a, alu_b, alu_mci, alu_rci,
        input  alu_y, alu_mco, alu_rco, alu_z, alu_v
    );

    modport master (
`ifdef ALU4_SEQ_ABORT_EN
        output abort,
`endif
        output start, op, dir, a, b, cin, rin,
        input  busy, done, result, cout, rout, zero, ovf,
        input  alu_op, alu_a, alu_b, alu_mci, alu_rci,
        output alu_y, alu_mco, alu_rco, alu_z, alu_v
    );
endinterface

// File: rtl/alu4_seq16.sv
// Issues one wide operation to a 4-bit ALU a nibble per clock, chaining carries.
// Optional ALU4_SEQ_ABORT_EN adds an abort input that cancels a running operation.
module alu4_seq16 #(
    parameter int NIBBLES = 4
) (
    input logic         clk,
    input logic         rst_n,
    alu4_seq16_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [3:0]     op_q;
    logic           dir_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [IW-1:0]  idx;
    logic           mc;
    logic           rc;
    logic           zacc;
    logic [W-1:0]   result_q;
    logic           cout_q;
    logic           rout_q;
    logic           zero_q;
    logic           ovf_q;

    logic [IW-1:0]  pos;
    logic [IW+1:0]  bit_lo;
    logic           last;
    logic           run;
    logic           abort_run;

    // MSB-first walks the nibbles downward from the top
    assign pos    = dir_q ? (LAST - idx) : idx;
    assign bit_lo = {pos, 2'b00};
    assign last   = (idx == LAST);
    assign run    = (state == RUN);

`ifdef ALU4_SEQ_ABORT_EN
    assign abort_run = run & bus.abort;
`else
    assign abort_run = 1'b0;
`endif

    assign bus.alu_op  = run ? op_q : 4'd0;
    assign bus.alu_a   = run ? a_q[bit_lo +: 4] : 4'd0;
    assign bus.alu_b   = run ? b_q[bit_lo +: 4] : 4'd0;
    assign bus.alu_mci = run & mc;
    assign bus.alu_rci = run & rc;

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.rout   = rout_q;
    assign bus.zero   = zero_q;
    assign bus.ovf    = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= '0;
            dir_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            idx      <= '0;
            mc       <= 1'b0;
            rc       <= 1'b0;
            zacc     <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            rout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= RUN;
                        op_q     <= bus.op;
                        dir_q    <= bus.dir;
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        idx      <= '0;
                        mc       <= bus.cin;
                        rc       <= bus.rin;
                        zacc     <= 1'b1;
                        result_q <= '0;
                        cout_q   <= 1'b0;
                        rout_q   <= 1'b0;
                        zero_q   <= 1'b0;
                        ovf_q    <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort_run) begin
                        // partial result and flags are left as they stand
                        state <= IDLE;
                        idx   <= '0;
                    end else begin
                        result_q[bit_lo +: 4] <= bus.alu_y;
                        mc   <= bus.alu_mco;
                        rc   <= bus.alu_rco;
                        zacc <= zacc & bus.alu_z;
                        if (last) begin
                            state  <= DONE;
                            idx    <= '0;
                            cout_q <= bus.alu_mco;
                            rout_q <= bus.alu_rco;
                            ovf_q  <= bus.alu_v;
                            zero_q <= zacc & bus.alu_z;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu4_seq16.sv
// Self-checking bench for alu4_seq16: behavioural 4-bit ALU plus a word-level reference model.
module tb_alu4_seq16;
    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu4_seq16_if #(.NIBBLES(NIBBLES)) bus ();
    alu4_seq16 #(.NIBBLES(NIBBLES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // 4-bit ALU: op0 add with carry (rotate carry passes through),
    // op1 rotate right through rci (math carry passes through)
    always_comb begin : alu_model
        logic [4:0] s;
        s = '0;
        bus.alu_y   = bus.alu_a ^ bus.alu_b;
        bus.alu_mco = bus.alu_mci;
        bus.alu_rco = bus.alu_rci;
        bus.alu_v   = 1'b0;
        case (bus.alu_op)
            4'd0: begin
                s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {4'd0, bus.alu_mci};
                bus.alu_y   = s[3:0];
                bus.alu_mco = s[4];
                bus.alu_v   = (bus.alu_a[3] == bus.alu_b[3]) && (s[3] != bus.alu_a[3]);
            end
            4'd1: begin
                bus.alu_y   = {bus.alu_rci, bus.alu_a[3:1]};
                bus.alu_rco = bus.alu_a[0];
            end
            default: ;
        endcase
        bus.alu_z = (bus.alu_y == 4'd0);
    end

    typedef struct packed {
        logic [W-1:0] res;
        logic cout, rout, zero, ovf;
    } exp_t;

    // whole-word view of what the nibble chain should produce
    function automatic exp_t ref_op(input logic [3:0] o, input logic [W-1:0] ra, rb,
                                    input logic ci, ri);
        exp_t e;
        logic [W:0] s;
        e = '0;
        if (o == 4'd0) begin
            s      = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, ci};
            e.res  = s[W-1:0];
            e.cout = s[W];
            e.rout = ri;
            e.ovf  = (ra[W-1] == rb[W-1]) && (e.res[W-1] != ra[W-1]);
        end else begin
            e.res  = {ri, ra[W-1:1]};
            e.cout = ci;
            e.rout = ra[0];
            e.ovf  = 1'b0;
        end
        e.zero = (e.res == '0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    int           lat;
    logic [3:0]   mci_seq;
    logic [W-1:0] a_seq;

    // starts one operation from IDLE; glitch >= 0 raises start during RUN on that cycle
    task automatic do_op(input string tag, input logic [3:0] o, input logic d,
                         input logic [W-1:0] ra, rb, input logic ci, ri, input int glitch);
        exp_t e;
        e = ref_op(o, ra, rb, ci, ri);
        bus.start = 1'b1; bus.op = o; bus.dir = d;
        bus.a = ra; bus.b = rb; bus.cin = ci; bus.rin = ri;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = ~ra; bus.b = ra ^ rb; bus.cin = ~ci; bus.rin = ~ri;
        lat = 0; mci_seq = '0; a_seq = '0;
        while (!bus.done && lat < 3 * NIBBLES) begin
            if (lat < NIBBLES) begin
                mci_seq[lat] = bus.alu_mci;
                a_seq[4*lat +: 4] = bus.alu_a;
            end
            bus.start = (lat == glitch);
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        chk({tag, ".lat"}, lat + 1, NIBBLES + 1);
        chk({tag, ".res"}, bus.result, e.res);
        chk({tag, ".flags"}, {bus.cout, bus.rout, bus.zero, bus.ovf},
            {e.cout, e.rout, e.zero, e.ovf});
        chk({tag, ".alu_done"}, {bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_mci, bus.alu_rci}, 0);
        @(posedge clk); #1;
        chk({tag, ".idle"}, {bus.busy, bus.done}, 0);
        chk({tag, ".hold"}, bus.result, e.res);
    endtask

    initial begin
        int   ndone;
        exp_t e;
        bus.start = 0; bus.op = 0; bus.dir = 0; bus.a = 0; bus.b = 0; bus.cin = 0; bus.rin = 0;
`ifdef ALU4_SEQ_ABORT_EN
        bus.abort = 0;
`endif
        #1;
        chk("rst.ctl", {bus.busy, bus.done, bus.cout, bus.rout, bus.zero, bus.ovf}, 0);
        chk("rst.res", bus.result, 0);
        chk("rst.alu", {bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_mci, bus.alu_rci}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("carry", 4'd0, 1'b0, 16'h0FFF, 16'h0001, 1'b0, 1'b0, -1);
        chk("carry.mci_seq", mci_seq, 4'b1110);
        do_op("wrap", 4'd0, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, -1);
        chk("wrap.fixed", {bus.result, bus.cout, bus.zero, bus.ovf}, {16'h0000, 3'b110});
        do_op("ovf", 4'd0, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, -1);
        chk("ovf.fixed", {bus.result, bus.ovf}, {16'h8000, 1'b1});
        do_op("rot", 4'd1, 1'b1, 16'h8421, 16'h0000, 1'b0, 1'b1, -1);
        chk("rot.order", a_seq, 16'h1248);
        chk("rot.fixed", {bus.result, bus.rout}, {16'hC210, 1'b1});

        // start raised mid-RUN with scrambled operands must change nothing
        do_op("glitch", 4'd0, 1'b0, 16'h1234, 16'h4321, 1'b1, 1'b0, 1);

        // start held for 10 cycles: one done, re-accept on the first IDLE cycle after DONE
        e = ref_op(4'd0, 16'hA5A5, 16'h0F0F, 1'b0, 1'b0);
        bus.start = 1; bus.op = 0; bus.dir = 0; bus.a = 16'hA5A5; bus.b = 16'h0F0F;
        bus.cin = 0; bus.rin = 0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i <= 6 && bus.done) ndone++;
            if (i == 4) chk("hold.done_at4", {bus.done, bus.result}, {1'b1, e.res});
            if (i == 5) chk("hold.idle_at5", bus.busy, 1'b0);
            if (i == 6) chk("hold.reaccept", bus.busy, 1'b1);
        end
        chk("hold.ndone", ndone, 1);
        bus.start = 0;
        lat = 0;
        while (!bus.done && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("hold.drain", bus.done, 1'b1);
        @(posedge clk); #1;

        // reset while RUN idx=2: outputs clear at once, no done
        bus.start = 1; bus.op = 0; bus.dir = 0; bus.a = 16'h1111; bus.b = 16'h2222;
        @(posedge clk); #1;
        bus.start = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rstmid.partial", bus.result, 16'h0033);
        rst_n = 1'b0;
        #1;
        chk("rstmid.ctl", {bus.busy, bus.done, bus.cout, bus.rout, bus.zero, bus.ovf}, 0);
        chk("rstmid.res", bus.result, 0);
        chk("rstmid.alu", {bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_mci, bus.alu_rci}, 0);
        @(posedge clk); #1;
        chk("rstmid.nodone", bus.done, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        do_op("after_rst", 4'd0, 1'b0, 16'h00F0, 16'h0010, 1'b0, 1'b0, -1);

`ifdef ALU4_SEQ_ABORT_EN
        bus.start = 1; bus.op = 0; bus.dir = 0; bus.a = 16'h1111; bus.b = 16'h1111;
        @(posedge clk); #1;
        bus.start = 0;
        @(posedge clk); #1;
        bus.abort = 1;
        @(posedge clk); #1;
        bus.abort = 0;
        chk("abort.idle", {bus.busy, bus.done}, 0);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        chk("abort.nodone", ndone, 0);
`endif

        for (int k = 0; k < 20; k++) begin
            logic s;
            s = 1'($urandom_range(0, 1));
            do_op("rand", {3'd0, s}, s, W'($urandom), W'($urandom),
                  1'($urandom), 1'($urandom), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
